rgb_line_doubler: RTL and testbench

//  Vertical 2x line-repeat stage placed directly downstream of the YUV->RGB converter.
//  - Captures each active line of 24-bit RGB pixels into one of two ping-pong line banks.
//  - Replays each captured line REPEAT times toward the HDMI output path.
//  - Valid/ready handshakes on both sides decouple the decoder pixel cadence from output timing.

---
 rtl/rgb_line_doubler.sv | 157 +++++++++++++++
 tb/tb_rgb_line_doubler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_line_doubler.sv
// rtl/rgb_line_doubler.sv - vertical line-repeat stage with ping-pong line banks
module rgb_line_doubler #(
    parameter int LINE_MAX = 720,
    parameter int PIX_W    = 24,
    parameter int REPEAT   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_rgb,
    input  logic             in_sol,
    input  logic             in_eol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_rgb,
    output logic             out_sol,
    output logic             out_eol,
    output logic             err_long
);

    localparam int AW = $clog2(LINE_MAX + 1);
    localparam int MW = $clog2(2 * LINE_MAX);
    localparam logic [AW-1:0] LMAX     = AW'(LINE_MAX);
    localparam logic [1:0]    LAST_REP = 2'(REPEAT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
    state_t state, state_nx;

    logic [PIX_W-1:0] mem [0:2*LINE_MAX-1];
    logic [PIX_W-1:0] ram_q;
    logic [1:0]       full;
    logic [AW-1:0]    len [2];

    logic             wr_bank;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    wr_eff;
    logic             wr_drop;
    logic             accept;
    logic             commit;
    logic [MW-1:0]    wr_idx;

    logic             rd_bank;
    logic [AW-1:0]    iss_addr;
    logic [1:0]       iss_rep;
    logic             iss_eol;
    logic [MW-1:0]    rd_idx;
    logic             sol_q, eol_q, last_q;
    logic             issue, free;
    logic [1:0]       commit_mask, free_mask;

    always_comb begin
        accept  = in_valid && in_ready;
        wr_eff  = in_sol ? '0 : wr_ptr;
        wr_drop = (wr_eff == LMAX);
        commit  = accept && in_eol;
        wr_idx  = wr_bank ? MW'(LINE_MAX) + MW'(wr_eff) : MW'(wr_eff);
        rd_idx  = rd_bank ? MW'(LINE_MAX) + MW'(iss_addr) : MW'(iss_addr);
        iss_eol = (iss_addr == len[rd_bank] - 1'b1);
        in_ready    = !full[wr_bank];
        commit_mask = commit ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
        free_mask   = free ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (accept && !wr_drop)
            mem[wr_idx] <= in_rgb;
    end

    // Read register loads only when the output advances, so it also holds
    // the presented pixel stable through downstream stalls.
    always_ff @(posedge clk) begin
        if (issue)
            ram_q <= mem[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank  <= 1'b0;
            wr_ptr   <= '0;
            err_long <= 1'b0;
            len[0]   <= '0;
            len[1]   <= '0;
            full     <= 2'b00;
        end else begin
            err_long <= accept && wr_drop;
            full     <= (full & ~free_mask) | commit_mask;
            if (accept) begin
                if (in_eol) begin
                    len[wr_bank] <= wr_drop ? LMAX : wr_eff + 1'b1;
                    wr_bank      <= ~wr_bank;
                    wr_ptr       <= '0;
                end else begin
                    wr_ptr <= wr_drop ? wr_eff : wr_eff + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_bank  <= 1'b0;
            iss_addr <= '0;
            iss_rep  <= '0;
            sol_q    <= 1'b0;
            eol_q    <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (free) begin
                rd_bank  <= ~rd_bank;
                iss_addr <= '0;
                iss_rep  <= '0;
            end else if (issue) begin
                sol_q  <= (iss_addr == '0);
                eol_q  <= iss_eol;
                last_q <= iss_eol && (iss_rep == LAST_REP);
                if (iss_eol) begin
                    iss_addr <= '0;
                    iss_rep  <= iss_rep + 1'b1;
                end else begin
                    iss_addr <= iss_addr + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nx  = state;
        issue     = 1'b0;
        free      = 1'b0;
        out_valid = (state == PLAY);
        out_rgb   = out_valid ? ram_q : '0;
        out_sol   = out_valid && sol_q;
        out_eol   = out_valid && eol_q;
        case (state)
            IDLE: if (full[rd_bank]) state_nx = LOAD;
            LOAD: begin
                issue    = 1'b1;
                state_nx = PLAY;
            end
            PLAY: begin
                if (out_ready) begin
                    if (last_q) begin
                        free     = 1'b1;
                        state_nx = full[~rd_bank] ? LOAD : IDLE;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rgb_line_doubler.sv
// tb/tb_rgb_line_doubler.sv - directed self-checking bench for rgb_line_doubler
module tb_rgb_line_doubler;

    localparam int LINE_MAX = 720;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_rgb = '0;
    logic        in_sol = 1'b0;
    logic        in_eol = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_rgb;
    logic        out_sol;
    logic        out_eol;
    logic        err_long;

    typedef struct packed {
        logic        fin;
        logic        sol;
        logic        eol;
        logic [23:0] rgb;
    } beat_t;

    beat_t expq[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    acc_cyc = 0;
    int    rise_cyc = 0;
    int    err_cnt = 0;
    bit    mon_en = 1'b0;
    bit    rand_mode = 1'b0;
    bit    chk_free = 1'b0;
    bit    free_pending = 1'b0;

    rgb_line_doubler #(.LINE_MAX(LINE_MAX), .PIX_W(24), .REPEAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_rgb(in_rgb),
        .in_sol(in_sol), .in_eol(in_eol),
        .out_valid(out_valid), .out_ready(out_ready), .out_rgb(out_rgb),
        .out_sol(out_sol), .out_eol(out_eol), .err_long(err_long)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    initial begin : monitor
        bit          prev_stall = 1'b0;
        bit          prev_valid = 1'b0;
        logic [25:0] prev_beat = '0;
        beat_t       e;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                if (prev_stall) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_beat", 32'({out_sol, out_eol, out_rgb}), 32'(prev_beat));
                end
                if (out_valid && !prev_valid) rise_cyc = cyc;
                if (err_long) err_cnt++;
                if (free_pending) begin
                    check("in_ready_after_free", 32'(in_ready), 32'd1);
                    free_pending = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        check("extra_beat", 32'(out_rgb), 32'hFFFF_FFFF);
                    end else begin
                        e = expq.pop_front();
                        check("out_beat", 32'({out_sol, out_eol, out_rgb}),
                              32'({e.sol, e.eol, e.rgb}));
                        if (e.fin && chk_free) begin
                            check("in_ready_at_free", 32'(in_ready), 32'd0);
                            chk_free = 1'b0;
                            free_pending = 1'b1;
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_valid = out_valid;
                prev_beat  = {out_sol, out_eol, out_rgb};
            end else begin
                prev_stall = 1'b0;
                prev_valid = 1'b0;
            end
        end
    end

    task automatic push(input logic [23:0] rgb, input logic sol, input logic eol, output int waited);
        in_valid = 1'b1;
        in_rgb   = rgb;
        in_sol   = sol;
        in_eol   = eol;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 3000) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic send_line(input logic [23:0] base, input int n, input bit model, output int max_wait);
        int w;
        int kept;
        beat_t b;
        kept = (n > LINE_MAX) ? LINE_MAX : n;
        if (model) begin
            for (int r = 0; r < 2; r++) begin
                for (int i = 0; i < kept; i++) begin
                    b.rgb = base + 24'(i);
                    b.sol = (i == 0);
                    b.eol = (i == kept - 1);
                    b.fin = (r == 1) && (i == kept - 1);
                    expq.push_back(b);
                end
            end
        end
        max_wait = 0;
        for (int i = 0; i < n; i++) begin
            push(base + 24'(i), i == 0, i == n - 1, w);
            if (w > max_wait) max_wait = w;
        end
        in_valid = 1'b0;
        in_sol   = 1'b0;
        in_eol   = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((expq.size() != 0 || out_valid) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, 32'(expq.size()), 32'd0);
    endtask

    initial begin : main
        int w;
        int w2;
        beat_t b;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_beat", 32'({out_sol, out_eol, out_rgb}), 32'd0);
        check("rst_err_long", 32'(err_long), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        mon_en = 1'b1;

        send_line(24'hA00000, 4, 1'b1, w);
        wait_drain("drain_t1");
        check("first_valid_latency", 32'(rise_cyc - acc_cyc), 32'd2);

        chk_free = 1'b1;
        send_line(24'h100000, 8, 1'b1, w);
        send_line(24'h200000, 8, 1'b1, w);
        send_line(24'h300000, 8, 1'b1, w2);
        check("l2_in_ready_dropped", 32'(w2 > 0), 32'd1);
        wait_drain("drain_t2");
        check("free_check_reached", 32'(chk_free), 32'd0);

        rand_mode = 1'b1;
        send_line(24'h400000, 8, 1'b1, w);
        wait_drain("drain_t3");
        rand_mode = 1'b0;
        check("no_err_before_long", 32'(err_cnt), 32'd0);

        err_cnt = 0;
        send_line(24'h500000, LINE_MAX + 3, 1'b1, w);
        wait_drain("drain_t4");
        check("err_long_pulses", 32'(err_cnt), 32'd3);

        b.rgb = 24'hFF8000; b.sol = 1'b1; b.eol = 1'b1; b.fin = 1'b0;
        expq.push_back(b);
        b.fin = 1'b1;
        expq.push_back(b);
        push(24'hFF8000, 1'b1, 1'b1, w);
        in_valid = 1'b0;
        in_sol   = 1'b0;
        in_eol   = 1'b0;
        wait_drain("drain_t5");

        mon_en = 1'b0;
        send_line(24'h600000, 8, 1'b0, w);
        push(24'h700000, 1'b1, 1'b0, w);
        push(24'h700001, 1'b0, 1'b0, w);
        push(24'h700002, 1'b0, 1'b0, w);
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_out_beat", 32'({out_sol, out_eol, out_rgb}), 32'd0);
        check("async_err_long", 32'(err_long), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        mon_en = 1'b1;
        send_line(24'h800000, 5, 1'b1, w);
        wait_drain("drain_t6");

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
